// File: rtl/controle_busca_raio.sv
// Sequencer for the four quadrant searchers: grows the shared radius ring by ring and reports the closest hit.
// Optional BUSCA watchdog with erroTimeout output is built in when BUSCA_TIMEOUT_EN is defined.
module controle_busca_raio #(
  parameter int TamanhoMalha     = 20,
  parameter int tamanhoDistancia = 8,
  parameter int RaioInicial      = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             iniciar,
  input  logic [3:0]                       quadFimRaio,
  input  logic [3:0]                       quadFinalizado,
  input  logic [3:0][tamanhoDistancia-1:0] quadDist,
  input  logic [3:0][tamanhoDistancia-1:0] quadX,
  input  logic [3:0][tamanhoDistancia-1:0] quadY,
  output logic [tamanhoDistancia-1:0]      raio,
  output logic                             raioAtualizado,
  output logic [3:0]                       enableQuad,
  output logic                             ocupado,
  output logic                             concluido,
  output logic                             encontrado,
  output logic [tamanhoDistancia-1:0]      melhorDist,
  output logic [tamanhoDistancia-1:0]      melhorX,
  output logic [tamanhoDistancia-1:0]      melhorY,
  output logic [1:0]                       melhorQuad
`ifdef BUSCA_TIMEOUT_EN
  ,
  output logic                             erroTimeout
`endif
);

  localparam logic [tamanhoDistancia-1:0] SEM_CAND = '1;
  localparam logic [tamanhoDistancia-1:0] RAIO_MAX = tamanhoDistancia'(TamanhoMalha - 1);
  localparam logic [tamanhoDistancia-1:0] RAIO_INI = tamanhoDistancia'(RaioInicial);

  typedef enum logic [2:0] {IDLE, BUSCA, AVALIA, ATUALIZA, SINCRONIZA, SELECIONA, FIM} estado_t;

  estado_t estado, proximo;

  logic [3:0]                  ativo, achou, finaliza, candidato, ativo_av, achou_av;
  logic                        fim_ok, timeout, sel_vld;
  logic [1:0]                  sel_quad;
  logic [tamanhoDistancia-1:0] sel_dist;

  always_comb begin
    candidato = '0;
    for (int i = 0; i < 4; i++) candidato[i] = (quadDist[i] != SEM_CAND);
    fim_ok   = &(quadFimRaio | ~ativo);
    finaliza = ativo & quadFinalizado;
    ativo_av = ativo & ~finaliza;
    achou_av = achou | (ativo & candidato);
  end

  // strict '<' keeps the lowest index on equal distances
  always_comb begin
    sel_vld  = 1'b0;
    sel_quad = 2'd0;
    sel_dist = SEM_CAND;
    for (int i = 0; i < 4; i++) begin
      if (achou[i] && (!sel_vld || quadDist[i] < sel_dist)) begin
        sel_vld  = 1'b1;
        sel_quad = 2'(i);
        sel_dist = quadDist[i];
      end
    end
  end

`ifdef BUSCA_TIMEOUT_EN
  localparam int LIMITE = TamanhoMalha * TamanhoMalha + 8;
  localparam int CW     = $clog2(LIMITE + 1);
  logic [CW-1:0] cnt_busca;

  always_ff @(posedge clock) begin
    if (reset || estado != BUSCA) cnt_busca <= '0;
    else                          cnt_busca <= cnt_busca + 1'b1;
  end

  assign timeout = (estado == BUSCA) && (cnt_busca == CW'(LIMITE - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) estado <= IDLE;
    else       estado <= proximo;
  end

  always_comb begin
    proximo   = estado;
    ocupado   = (estado != IDLE) && (estado != FIM);
    concluido = (estado == FIM);
    case (estado)
      IDLE:       if (iniciar) proximo = BUSCA;
      BUSCA:      if (timeout) proximo = SELECIONA;
                  else if (fim_ok) proximo = AVALIA;
      AVALIA:     proximo = (|achou_av || ativo_av == 4'b0000 || raio >= RAIO_MAX) ? SELECIONA : ATUALIZA;
      ATUALIZA:   proximo = SINCRONIZA;
      SINCRONIZA: proximo = BUSCA;
      SELECIONA:  proximo = FIM;
      FIM:        proximo = IDLE;
      default:    proximo = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      raio           <= '0;
      raioAtualizado <= 1'b0;
      enableQuad     <= 4'b0000;
      ativo          <= 4'b0000;
      achou          <= 4'b0000;
      encontrado     <= 1'b0;
      melhorDist     <= SEM_CAND;
      melhorX        <= '0;
      melhorY        <= '0;
      melhorQuad     <= 2'd0;
`ifdef BUSCA_TIMEOUT_EN
      erroTimeout    <= 1'b0;
`endif
    end else begin
      raioAtualizado <= 1'b0;
      case (estado)
        IDLE: if (iniciar) begin
          raio       <= RAIO_INI;
          enableQuad <= 4'b1111;
          ativo      <= 4'b1111;
          achou      <= 4'b0000;
          encontrado <= 1'b0;
`ifdef BUSCA_TIMEOUT_EN
          erroTimeout <= 1'b0;
`endif
        end
        BUSCA: if (timeout) begin
          achou <= 4'b0000;
`ifdef BUSCA_TIMEOUT_EN
          erroTimeout <= 1'b1;
`endif
        end
        // enable drops here so a finished searcher never sees the next radius pulse
        AVALIA: begin
          ativo      <= ativo_av;
          enableQuad <= enableQuad & ~finaliza;
          achou      <= achou_av;
        end
        ATUALIZA: begin
          raio           <= raio + 1'b1;
          raioAtualizado <= 1'b1;
        end
        SELECIONA: begin
          enableQuad <= 4'b0000;
          encontrado <= sel_vld;
          if (sel_vld) begin
            melhorDist <= sel_dist;
            melhorX    <= quadX[sel_quad];
            melhorY    <= quadY[sel_quad];
            melhorQuad <= sel_quad;
          end else begin
            melhorDist <= SEM_CAND;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
